// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, the
// redirect source and the decode stage. The fetch queue uses the master
// modport; the surrounding system uses the slave modport.
// The optional misalign_err flag exists only when FETCH_MISALIGN_CHK_EN
// is defined.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_op;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            misalign_err;
`endif

  modport master (
`ifdef FETCH_MISALIGN_CHK_EN
    output misalign_err,
`endif
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_instr, out_pc, out_op
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHK_EN
    input  misalign_err,
`endif
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_instr, out_pc, out_op
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, buffers the
// in-order responses in a DEPTH-entry queue and presents the head to decode.
// A redirect flushes the queue; responses still in flight for the old path
// are counted off in the DRAIN state and discarded.
// Optional macro FETCH_MISALIGN_CHK_EN adds a sticky misalign_err flag that
// is raised by any redirect whose target is not word aligned.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_V  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_head_pc;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [31:0]     r_mem [DEPTH];

  logic            w_credit;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_rsp_ok;
  logic            w_push;
  logic            w_out_valid;
  logic            w_pop;
  logic [XLEN-1:0] w_tgt_pc;
  logic [CW-1:0]   w_drop;
  logic [31:0]     w_out_instr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Queue entries plus in-flight requests never exceed DEPTH, so a response
  // always has a free slot waiting for it.
  assign w_credit    = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_V;
  assign w_req_valid = !reset && (r_state == RUN) && !bus.redirect_valid && w_credit;
  assign w_fire      = w_req_valid && bus.imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_ok    = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_push      = !reset && !bus.redirect_valid && (r_state == RUN) && w_rsp_ok;

  assign w_out_valid = (r_count != '0) && (r_state == RUN);
  assign w_pop       = w_out_valid && bus.out_ready;

  assign w_tgt_pc    = bus.redirect_pc & ~XLEN'(3);
  assign w_drop      = r_outstanding - CW'(w_rsp_ok);

  assign w_out_instr = w_out_valid ? r_mem[r_head] : '0;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_instr      = w_out_instr;
  assign bus.out_pc         = r_head_pc;
  assign bus.out_op         = w_out_instr[6:0];

  // Control state: PCs, occupancy, credit tracking and the RUN/DRAIN FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_head_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc    <= w_tgt_pc;
      r_head_pc     <= w_tgt_pc;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_drop_cnt    <= w_drop;
      r_outstanding <= w_drop;
      r_state       <= (w_drop != '0) ? DRAIN : RUN;
    end else if (r_state == RUN) begin
      if (w_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_rsp_ok) begin
        r_tail <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head    <= ptr_inc(r_head);
        r_head_pc <= r_head_pc + XLEN'(4);
      end
      r_count       <= r_count + CW'(w_rsp_ok) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(w_rsp_ok);
    end else begin
      if (bus.imem_rsp_valid && (r_drop_cnt != '0)) begin
        r_drop_cnt    <= r_drop_cnt - CW'(1);
        r_outstanding <= r_outstanding - CW'(1);
        if (r_drop_cnt == CW'(1)) begin
          r_state <= RUN;
        end
      end
    end
  end

  // Instruction storage; written at the tail when a live response arrives.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= bus.imem_rsp_data;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign_err;

  // Sticky flag for redirect targets with low address bits set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign_err <= 1'b0;
    end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign bus.misalign_err = r_misalign_err;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that issues sequential word fetches to instruction memory and buffers returned instructions in a small in-order queue.
- Presents one instruction at a time, with its PC and opcode field, to the decode stage. out_op drives the main decoder's op input directly.
- Handles control-flow redirects (taken branch, jal) by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset.
- DEPTH, 2: instruction queue entries, which is also the maximum number of outstanding requests plus buffered entries. Legal range 2..8.
- XLEN, 32: address and instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  control-flow change this cycle.
- redirect_pc  input  XLEN  target PC of the redirect.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  XLEN  fetch address, word aligned.
- imem_rsp_valid  input  1  response data valid. Responses are in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- out_valid  output  1  head instruction valid.
- out_ready  input  1  decode consumes the head.
- out_instr  output  32  head instruction.
- out_pc  output  XLEN  PC of the head instruction.
- out_op  output  7  out_instr[6:0], fed to the main decoder.

Behaviour:
- Reset values:
  - Internal registers: fetch_pc=RESET_PC, head_pc=RESET_PC, count=0, outstanding=0, drop_cnt=0, state=RUN.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=RESET_PC, out_op=0.
  - Reset has priority over every other input in the same cycle, including a redirect or response. A reset mid-transaction abandons all outstanding requests; responses arriving after reset are ignored until the first new request is accepted.
- Credit rule: imem_req_valid = (state==RUN) && !redirect_valid && (count + outstanding < DEPTH). The queue therefore never overflows.
- Request handshake:
  - A request fires when imem_req_valid && imem_req_ready.
  - On fire: outstanding+1 and fetch_pc+=4, wrapping modulo 2^XLEN.
  - imem_req_addr = fetch_pc, held stable while valid && !ready.
- Response handling:
  - In RUN, imem_rsp_valid pushes imem_rsp_data at the tail and decrements outstanding.
  - A response with outstanding==0 is a protocol error and is ignored.
- Output handshake:
  - out_valid = (count != 0) && (state==RUN).
  - Head pops when out_valid && out_ready; on pop, head_pc += 4.
  - Combinational from the head entry: out_instr = head data, out_pc = head_pc, out_op = head data[6:0].
  - Zero-count bypass is not allowed: minimum fetch-to-out_valid latency is memory latency + 1 cycle.
- Simultaneous push and pop: both occur and count is unchanged. Push into an empty queue and pop in the same cycle is impossible because out_valid is 0.
- Pointers: head and tail pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1), applied in the same cycle:
  - Queue flushed: count=0.
  - fetch_pc=head_pc=redirect_pc with bits [1:0] cleared.
  - drop_cnt=outstanding, minus 1 if a response is also arriving this cycle; that response is discarded.
  - outstanding=drop_cnt.
  - Any pop in that cycle is ignored.
  - No request is issued in the redirect cycle.
  - Next state: DRAIN if the new drop_cnt != 0, otherwise RUN.
- FSM:
  - RUN: normal operation.
  - DRAIN: no requests and out_valid=0. Each response decrements drop_cnt and outstanding and its data is discarded. On the last stale response, go to RUN the next cycle.
  - A redirect during DRAIN reloads the PCs and recomputes drop_cnt as above.
- Width: count and outstanding are clog2(DEPTH+1) bits. Arithmetic never underflows under legal protocol.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - Set sticky on any redirect with redirect_pc[1:0] != 0; cleared only by reset.
  - The redirect is still applied with bits [1:0] cleared.
- Undefined: no port, and misaligned targets are silently aligned.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory returning 32'h00000013, out_ready=1.
  - First request addr=0x0, then 0x4, 0x8.
  - First out_valid 2 cycles after first fire with out_pc=0, out_op=7'b0010011.
- out_ready=0 with memory ready: exactly DEPTH=2 requests fire (0x0, 0x4), then imem_req_valid=0. Raising out_ready pops 0x0 and then the next request addr=0x8 fires.
- Redirect to 0x100 with 2 outstanding requests on a 3-cycle memory:
  - State goes to DRAIN and both stale responses are dropped.
  - The next request addr is 0x100.
  - The first out_pc after the redirect is 0x100.
- Redirect in the same cycle as a response and a pop: the response is discarded, count=0, no request that cycle, and the next request addr=redirect target.
- Wrap-around: RESET_PC=32'hFFFF_FFFC gives fetch addresses 0xFFFFFFFC then 0x00000000, and out_pc follows the same sequence.
- With FETCH_MISALIGN_CHK_EN: redirect_pc=0x102 sets misalign_err=1, the next request addr is 0x100, and misalign_err stays 1 until reset.
